display_fetch_ctrl: RTL and testbench
=====================================

Name: display_fetch_ctrl

Overview:
Fills the 128x64-bit display buffer from system memory, one scan line ahead of scanout. Treats the buffer as two 64-word ping-pong banks: scanout reads bank scan_bank while this block fetches the next line into the other bank. Issues pipelined word reads on the memory bus and writes the in-order responses into the buffer. Flags underrun when a new line starts before the previous fetch has finished.

Parameters:
WORDS_PER_LINE, 64, words fetched per line; 1..64
ADDR_WIDTH, 24, memory word-address width
MAX_OUTSTANDING, 8, maximum accepted-but-unanswered bus reads; 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  accept line_start when 1
line_start  in  1  single-cycle pulse: swap banks, prefetch next line
line_base_addr  in  ADDR_WIDTH  word address of next line; sampled with line_start
underrun_clear  in  1  clears underrun
scan_bank  out  1  bank scanout must read (buffer read_addr[6])
fetch_busy  out  1  fetch or drain in progress
underrun  out  1  sticky: line_start arrived while fetch_busy
bus_enable  out  1  read request valid
bus_addr  out  ADDR_WIDTH  read word address
bus_ready  in  1  request accepted when bus_enable && bus_ready
bus_read_data  in  64  response data, in request order
bus_read_data_valid  in  1  response strobe
buf_write_addr  out  7  to display buffer write_addr
buf_write_data  out  64  to display buffer write_data
buf_write_enable  out  1  to display buffer write_enable

Behaviour:
- One clock, clk; reset synchronous, active-high. Reset values: scan_bank=0, fetch_busy=0, underrun=0, bus_enable=0, bus_addr=0, buf_write_enable=0, buf_write_addr=0, buf_write_data=0. Internal counters are 0 and state is IDLE.
- States: IDLE, FETCH (issuing requests), WAIT (all requests issued, responses pending), DRAIN (discarding responses from an aborted fetch).
- Line start is accepted only when line_start && enable. On acceptance in cycle N:
  - scan_bank toggles at N+1.
  - fill_bank = new scan_bank inverted, i.e. the bank scanout just left.
  - base is latched from line_base_addr; issue_cnt and recv_cnt are cleared.
- Next state after acceptance:
  - From IDLE: FETCH.
  - From FETCH or WAIT with outstanding>0: DRAIN.
  - From FETCH or WAIT with outstanding==0: FETCH.
  - From DRAIN: stay in DRAIN.
  - Acceptance while fetch_busy=1 sets underrun.
  - In DRAIN the latest base wins.
- Issue rule: bus_enable=1 iff state==FETCH, issue_cnt<WORDS_PER_LINE and outstanding<MAX_OUTSTANDING. bus_addr = base + issue_cnt (mod 2^ADDR_WIDTH). issue_cnt increments on acceptance. bus_enable and bus_addr are combinational from registered state. When issue_cnt reaches WORDS_PER_LINE, state goes to WAIT.
- outstanding counter: +1 on request acceptance, -1 on bus_read_data_valid. Both in the same cycle leave it unchanged. A valid strobe with outstanding==0 is ignored entirely.
- Response in FETCH or WAIT at cycle M produces, at M+1:
  - buf_write_enable=1
  - buf_write_addr={fill_bank, recv_cnt[5:0]}
  - buf_write_data=bus_read_data
  - recv_cnt increments.
  When recv_cnt reaches WORDS_PER_LINE, state goes to IDLE. buf_write_enable is 0 in all other cycles.
- Response in DRAIN: decrements outstanding with no buffer write. When outstanding reaches 0, state goes to FETCH using the latched base, with issue_cnt and recv_cnt at 0.
- fetch_busy = (state != IDLE), registered with the state.
- Writes never target scan_bank. A bank swap during FETCH or WAIT routes no further responses to the old fill bank.
- enable=0 blocks only new line_start; a fetch already in progress completes normally.
- underrun_clear clears underrun. If a set and a clear occur in the same cycle, set wins.
- Reset mid-operation forces all reset values immediately. Reset of the memory bus is a system requirement; stray responses after reset are ignored by the outstanding==0 rule.

Test Plan:
- Reset, then line_start with base=0x1000, bus_ready=1, responses 2 cycles after each request with data=addr -> scan_bank=1; buffer writes to addresses 0..63 with data 0x1000..0x103F; fetch_busy falls one cycle after the 64th write; underrun=0.
- Same as above with bus_ready=1 and no responses -> exactly 8 requests (0x1000..0x1007), then bus_enable=0. One response re-enables one further request, to 0x1008.
- Fetch into bank 0 completes, then a second line_start with base=0x2000 -> scan_bank=0; writes go to addresses 64..127.
- line_start at issue_cnt=10 with 5 responses outstanding, new base=0x3000 -> underrun=1; the 5 responses produce no buffer writes; the next request is 0x3000 after the last drained response.
- line_start with enable=0 -> no bank swap and no requests. Then underrun_clear together with a new underrun event -> underrun stays 1.
- Assert reset during WAIT -> all outputs return to reset values next cycle; a subsequent stray bus_read_data_valid causes no write.

Source files
------------

// File: rtl/display_fetch_ctrl_if.sv
// Memory-bus and display-buffer write signals of the display line fetcher.
//   master : the fetch controller (drives read requests and buffer writes)
//   slave  : the memory / buffer side (answers requests in order)
// Signals:
//   bus_enable / bus_addr / bus_ready          read request handshake
//   bus_read_data / bus_read_data_valid        in-order read responses
//   buf_write_addr / _data / _enable           display buffer write port
interface display_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  bus_enable;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_ready;
    logic [63:0]           bus_read_data;
    logic                  bus_read_data_valid;
    logic [6:0]            buf_write_addr;
    logic [63:0]           buf_write_data;
    logic                  buf_write_enable;

    modport master (
        output bus_enable, bus_addr, buf_write_addr, buf_write_data, buf_write_enable,
        input  bus_ready, bus_read_data, bus_read_data_valid
    );

    modport slave (
        input  bus_enable, bus_addr, buf_write_addr, buf_write_data, buf_write_enable,
        output bus_ready, bus_read_data, bus_read_data_valid
    );
endinterface

// File: rtl/display_fetch_ctrl.sv
// Display line prefetcher. The 128x64 display buffer is split into two
// 64-word banks; scanout reads bank scan_bank while this block fetches the
// next line from memory into the other bank. Each accepted line_start swaps
// the banks and starts a new fetch from line_base_addr. If the previous fetch
// still has reads in flight, those responses are drained and discarded before
// the new fetch starts, and the sticky underrun flag is raised.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   enable, line_start     line_start is honoured only while enable=1
//   line_base_addr         word address of the next line, sampled with line_start
//   underrun_clear         clears underrun (a simultaneous set wins)
//   scan_bank              bank scanout must read
//   fetch_busy             fetch or drain in progress
//   underrun               sticky: a line started while fetch_busy
//   bus                    memory read bus and display buffer write port
module display_fetch_ctrl #(
    parameter int WORDS_PER_LINE  = 64,
    parameter int ADDR_WIDTH      = 24,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  line_start,
    input  logic [ADDR_WIDTH-1:0] line_base_addr,
    input  logic                  underrun_clear,
    output logic                  scan_bank,
    output logic                  fetch_busy,
    output logic                  underrun,
    display_fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [6:0] WORDS_C = 7'(WORDS_PER_LINE);
    localparam logic [3:0] MAX_C   = 4'(MAX_OUTSTANDING);

    state_t                state_r, state_nxt_s;
    logic [6:0]            issue_cnt_r, issue_cnt_nxt_s;
    logic [6:0]            recv_cnt_r, recv_cnt_nxt_s;
    logic [3:0]            out_cnt_r, out_cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] base_r, base_nxt_s;
    logic                  scan_bank_r, scan_bank_nxt_s;
    logic                  underrun_r, underrun_nxt_s;
    logic                  fetch_busy_r;
    logic                  wr_en_r, wr_en_nxt_s;
    logic [6:0]            wr_addr_r, wr_addr_nxt_s;
    logic [63:0]           wr_data_r, wr_data_nxt_s;

    logic                  accept_s;
    logic                  bus_enable_s;
    logic                  req_fire_s;
    logic                  rsp_s;

    assign accept_s     = line_start && enable;
    assign bus_enable_s = (state_r == ST_FETCH) && (issue_cnt_r < WORDS_C) && (out_cnt_r < MAX_C);
    assign req_fire_s   = bus_enable_s && bus.bus_ready;
    // A strobe with nothing in flight is a stray (e.g. after reset) and is ignored.
    assign rsp_s        = bus.bus_read_data_valid && (out_cnt_r != 4'd0);

    assign bus.bus_enable       = bus_enable_s;
    assign bus.bus_addr         = base_r + ADDR_WIDTH'(issue_cnt_r);
    assign bus.buf_write_enable = wr_en_r;
    assign bus.buf_write_addr   = wr_addr_r;
    assign bus.buf_write_data   = wr_data_r;
    assign scan_bank            = scan_bank_r;
    assign fetch_busy           = fetch_busy_r;
    assign underrun             = underrun_r;

    // Outstanding-read counter update
    always_comb begin
        out_cnt_nxt_s = out_cnt_r;
        case ({req_fire_s, rsp_s})
            2'b10:   out_cnt_nxt_s = out_cnt_r + 4'd1;
            2'b01:   out_cnt_nxt_s = out_cnt_r - 4'd1;
            default: out_cnt_nxt_s = out_cnt_r;
        endcase
    end

    // Next-state, counters, bank swap, underrun and buffer-write generation
    always_comb begin
        state_nxt_s     = state_r;
        issue_cnt_nxt_s = issue_cnt_r;
        recv_cnt_nxt_s  = recv_cnt_r;
        base_nxt_s      = base_r;
        scan_bank_nxt_s = scan_bank_r;
        underrun_nxt_s  = underrun_r;
        wr_en_nxt_s     = 1'b0;
        wr_addr_nxt_s   = wr_addr_r;
        wr_data_nxt_s   = wr_data_r;

        if (req_fire_s) begin
            issue_cnt_nxt_s = issue_cnt_r + 7'd1;
        end else begin
            issue_cnt_nxt_s = issue_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_FETCH, ST_WAIT: begin
                if (rsp_s) begin
                    // The fill bank is always the one scanout is not reading.
                    wr_en_nxt_s    = 1'b1;
                    wr_addr_nxt_s  = {~scan_bank_r, recv_cnt_r[5:0]};
                    wr_data_nxt_s  = bus.bus_read_data;
                    recv_cnt_nxt_s = recv_cnt_r + 7'd1;
                end else begin
                    recv_cnt_nxt_s = recv_cnt_r;
                end
                if ((state_r == ST_FETCH) && (issue_cnt_r == WORDS_C)) begin
                    state_nxt_s = ST_WAIT;
                end else if ((state_r == ST_WAIT) && (recv_cnt_r == WORDS_C)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_nxt_s == 4'd0) begin
                    state_nxt_s     = ST_FETCH;
                    issue_cnt_nxt_s = 7'd0;
                    recv_cnt_nxt_s  = 7'd0;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A new line overrides everything above. A response arriving in the
        // same cycle belongs to the abandoned line and is not written, so the
        // new scan bank is never overwritten.
        if (accept_s) begin
            scan_bank_nxt_s = ~scan_bank_r;
            base_nxt_s      = line_base_addr;
            issue_cnt_nxt_s = 7'd0;
            recv_cnt_nxt_s  = 7'd0;
            wr_en_nxt_s     = 1'b0;
            wr_addr_nxt_s   = wr_addr_r;
            wr_data_nxt_s   = wr_data_r;
            if (state_r == ST_IDLE) begin
                state_nxt_s = ST_FETCH;
            end else if (out_cnt_nxt_s != 4'd0) begin
                state_nxt_s = ST_DRAIN;
            end else begin
                state_nxt_s = ST_FETCH;
            end
        end else begin
            scan_bank_nxt_s = scan_bank_r;
        end

        if (accept_s && fetch_busy_r) begin
            underrun_nxt_s = 1'b1;
        end else if (underrun_clear) begin
            underrun_nxt_s = 1'b0;
        end else begin
            underrun_nxt_s = underrun_r;
        end
    end

    // State and registered output update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            issue_cnt_r  <= 7'd0;
            recv_cnt_r   <= 7'd0;
            out_cnt_r    <= 4'd0;
            base_r       <= {ADDR_WIDTH{1'b0}};
            scan_bank_r  <= 1'b0;
            underrun_r   <= 1'b0;
            fetch_busy_r <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= 7'd0;
            wr_data_r    <= 64'd0;
        end else begin
            state_r      <= state_nxt_s;
            issue_cnt_r  <= issue_cnt_nxt_s;
            recv_cnt_r   <= recv_cnt_nxt_s;
            out_cnt_r    <= out_cnt_nxt_s;
            base_r       <= base_nxt_s;
            scan_bank_r  <= scan_bank_nxt_s;
            underrun_r   <= underrun_nxt_s;
            fetch_busy_r <= (state_nxt_s != ST_IDLE);
            wr_en_r      <= wr_en_nxt_s;
            wr_addr_r    <= wr_addr_nxt_s;
            wr_data_r    <= wr_data_nxt_s;
        end
    end
endmodule

// File: tb/tb_display_fetch_ctrl.sv
module tb_display_fetch_ctrl;
    localparam int W    = 64;
    localparam int AW   = 24;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          line_start;
    logic [AW-1:0] line_base_addr;
    logic          underrun_clear;
    logic          scan_bank;
    logic          fetch_busy;
    logic          underrun;

    display_fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    display_fetch_ctrl #(
        .WORDS_PER_LINE(W), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .line_start(line_start),
        .line_base_addr(line_base_addr), .underrun_clear(underrun_clear),
        .scan_bank(scan_bank), .fetch_busy(fetch_busy), .underrun(underrun),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        int            due;
    } req_t;

    req_t          pend_q[$];   // accepted requests awaiting their response
    logic [AW-1:0] req_q[$];    // every accepted request address, in order
    logic [70:0]   wr_q[$];     // every buffer write {addr, data}
    int            cyc = 0;
    int            n_out = 0;
    int            n_req = 0;
    int            n_resp = 0;
    int            resp_budget = -1;
    int            req_limit = -1;
    int            ready_pct = 100;
    int            lat_fixed = 2;
    int            last_wr_cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic          mdl_scan = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs just after the edge, then drive the memory side.
    task automatic tick();
        req_t r;
        logic rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.buf_write_enable) begin
            wr_q.push_back({bus.buf_write_addr, bus.buf_write_data});
            last_wr_cyc = cyc;
        end
        if (n_out >= MAXO) check("out_limit", bus.bus_enable, 1'b0);
        bus.bus_read_data_valid = 1'b0;
        bus.bus_read_data       = 64'h0;
        if (pend_q.size() > 0 && resp_budget != 0 && pend_q[0].due <= cyc + 1) begin
            r = pend_q.pop_front();
            bus.bus_read_data_valid = 1'b1;
            bus.bus_read_data       = {40'h0, r.addr};
            n_out--;
            n_resp++;
            if (resp_budget > 0) resp_budget--;
        end
        rdy = ((req_limit < 0) || (n_req < req_limit)) && ($urandom_range(0, 99) < ready_pct);
        bus.bus_ready = rdy;
        if (rdy && bus.bus_enable) begin
            r.addr = bus.bus_addr;
            r.due  = cyc + 1 + ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4)));
            pend_q.push_back(r);
            req_q.push_back(bus.bus_addr);
            n_out++;
            n_req++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        pend_q.delete();
        n_out = 0;
        n_req = 0;
        bus.bus_read_data_valid = 1'b0;
        mdl_scan = 1'b0;
        tick();
    endtask

    task automatic pulse_line(input logic [AW-1:0] base, input logic clr);
        line_base_addr = base;
        line_start     = 1'b1;
        underrun_clear = clr;
        tick();
        line_start     = 1'b0;
        underrun_clear = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (fetch_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", fetch_busy, 1'b0);
    endtask

    // Reference: a line at base yields requests base+i and writes of word
    // base+i into slot i of the bank scanout is not reading.
    task automatic verify_line(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        check("scan_bank", scan_bank, mdl_scan);
        check("req_count", req_q.size(), W);
        for (int i = 0; i < W && i < req_q.size(); i++) begin
            a = base + AW'(i);
            check("req_addr", req_q[i], a);
        end
        check("wr_count", wr_q.size(), W);
        for (int i = 0; i < W && i < wr_q.size(); i++) begin
            a = base + AW'(i);
            check("wr_word", wr_q[i], {~mdl_scan, 6'(i), 40'h0, a});
        end
    endtask

    task automatic run_line(input logic [AW-1:0] base);
        req_q.delete();
        wr_q.delete();
        pulse_line(base, 1'b0);
        mdl_scan = ~mdl_scan;
        wait_idle(3000);
        verify_line(base);
        check("underrun_clean", underrun, 1'b0);
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        enable         = 1'b1;
        line_start     = 1'b0;
        line_base_addr = '0;
        underrun_clear = 1'b0;
        bus.bus_ready           = 1'b0;
        bus.bus_read_data       = 64'h0;
        bus.bus_read_data_valid = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_scan", scan_bank, 1'b0);
        check("rst_busy", fetch_busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_bus_en", bus.bus_enable, 1'b0);
        check("rst_bus_addr", bus.bus_addr, 24'h0);
        check("rst_wr_en", bus.buf_write_enable, 1'b0);
        check("rst_wr_addr", bus.buf_write_addr, 7'h0);
        check("rst_wr_data", bus.buf_write_data, 64'h0);
        reset = 1'b0;
        tick();

        // Full line into bank 0, responses two cycles after each request
        ready_pct = 100; lat_fixed = 2; resp_budget = -1; req_limit = -1;
        run_line(24'h001000);
        check("busy_fall", cyc - last_wr_cyc, 1);

        // Second line lands in bank 1 (addresses 64..127)
        run_line(24'h002000);

        // No responses: issue stops at the outstanding limit, one response frees one slot
        do_reset();
        resp_budget = 0; lat_fixed = 1;
        req_q.delete();
        pulse_line(24'h001000, 1'b0);
        repeat (20) tick();
        check("limit_count", req_q.size(), MAXO);
        for (int i = 0; i < MAXO && i < req_q.size(); i++) check("limit_addr", req_q[i], 24'h001000 + 24'(i));
        check("limit_bus_en", bus.bus_enable, 1'b0);
        resp_budget = 1;
        repeat (10) tick();
        check("limit_next_count", req_q.size(), MAXO + 1);
        if (req_q.size() > MAXO) check("limit_next_addr", req_q[MAXO], 24'h001008);

        // Abort with reads in flight: drain, underrun, restart from the new base
        do_reset();
        resp_budget = 5; req_limit = 10; n_req = 0; lat_fixed = 1;
        req_q.delete(); wr_q.delete();
        pulse_line(24'h001000, 1'b0);
        mdl_scan = ~mdl_scan;
        repeat (20) tick();
        check("pre_abort_reqs", req_q.size(), 10);
        check("pre_abort_wrs", wr_q.size(), 5);
        check("pre_abort_underrun", underrun, 1'b0);
        req_q.delete(); wr_q.delete(); n_resp = 0;
        pulse_line(24'h003000, 1'b0);
        mdl_scan = ~mdl_scan;
        check("abort_underrun", underrun, 1'b1);
        check("abort_busy", fetch_busy, 1'b1);
        check("drain_bus_en", bus.bus_enable, 1'b0);
        resp_budget = -1; req_limit = -1;
        n = 0;
        while (req_q.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_resp_count", n_resp, 5);
        check("drain_no_writes", wr_q.size(), 0);
        if (req_q.size() > 0) check("restart_addr", req_q[0], 24'h003000);
        wait_idle(3000);
        verify_line(24'h003000);

        // enable=0 ignores line_start
        enable = 1'b0;
        req_q.delete();
        pulse_line(24'h004000, 1'b0);
        repeat (5) tick();
        check("dis_scan", scan_bank, mdl_scan);
        check("dis_reqs", req_q.size(), 0);
        check("dis_busy", fetch_busy, 1'b0);
        enable = 1'b1;

        // underrun clear alone, then clear colliding with a new underrun
        resp_budget = 0;
        pulse_line(24'h004000, 1'b0);
        mdl_scan = ~mdl_scan;
        repeat (12) tick();
        underrun_clear = 1'b1;
        tick();
        underrun_clear = 1'b0;
        check("clear_alone", underrun, 1'b0);
        req_q.delete(); wr_q.delete();
        pulse_line(24'h005000, 1'b1);
        mdl_scan = ~mdl_scan;
        check("set_beats_clear", underrun, 1'b1);
        resp_budget = -1;
        wait_idle(3000);
        verify_line(24'h005000);

        // Reset during WAIT, then a stray response
        resp_budget = W - 4; req_limit = -1; lat_fixed = 1;
        req_q.delete(); wr_q.delete();
        pulse_line(24'h006000, 1'b0);
        n = 0;
        while (req_q.size() < W && n < 400) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("wait_busy", fetch_busy, 1'b1);
        check("wait_bus_en", bus.bus_enable, 1'b0);
        check("wait_wrs", wr_q.size(), W - 4);
        reset = 1'b1;
        tick();
        check("mid_rst_scan", scan_bank, 1'b0);
        check("mid_rst_busy", fetch_busy, 1'b0);
        check("mid_rst_underrun", underrun, 1'b0);
        check("mid_rst_bus_en", bus.bus_enable, 1'b0);
        check("mid_rst_bus_addr", bus.bus_addr, 24'h0);
        check("mid_rst_wr_en", bus.buf_write_enable, 1'b0);
        check("mid_rst_wr_addr", bus.buf_write_addr, 7'h0);
        check("mid_rst_wr_data", bus.buf_write_data, 64'h0);
        tick();
        reset = 1'b0;
        pend_q.delete(); n_out = 0; resp_budget = -1; mdl_scan = 1'b0;
        wr_q.delete();
        bus.bus_read_data_valid = 1'b1;
        bus.bus_read_data       = 64'h0000_0000_00DE_ADBE;
        tick();
        tick();
        check("stray_no_write", wr_q.size(), 0);
        check("stray_busy", fetch_busy, 1'b0);
        check("stray_bus_en", bus.bus_enable, 1'b0);

        // Randomized lines: random bus stalls, latencies and bases (one wraps)
        do_reset();
        lat_fixed = 0;
        for (int k = 0; k < 6; k++) begin
            ready_pct = int'($urandom_range(20, 100));
            if (k == 2) run_line(24'hFFFFF0);
            else run_line(AW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
